// File: rtl/nec_ir_tx_if.sv
// Start/frame handshake and IR outputs of the NEC transmitter, grouped for port connection.
// master drives the request side; slave is the transmitter.
interface nec_ir_tx_if;
  logic        Start;
  logic [31:0] DataIn;
  logic        Busy;
  logic        Done;
  logic        IrOut;
  logic        IrLed;

  modport master (output Start, DataIn, input Busy, Done, IrOut, IrLed);
  modport slave  (input Start, DataIn, output Busy, Done, IrOut, IrLed);
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: leader, 32 pulse-distance bits LSB-first, stop mark, gap.
// Define NEC_TX_CARRIER_EN to carrier-modulate IrLed during marks; otherwise IrLed = ~IrOut.
module nec_ir_tx #(
  parameter int unsigned LEAD_LOW     = 450000,
  parameter int unsigned LEAD_HIGH    = 225000,
  parameter int unsigned BIT_LOW      = 28000,
  parameter int unsigned ZERO_HIGH    = 28000,
  parameter int unsigned ONE_HIGH     = 84500,
  parameter int unsigned GAP          = 2000000,
  parameter int unsigned CARRIER_HALF = 658
) (
  input  logic         clk,
  input  logic         Reset,
  nec_ir_tx_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD_L = 3'd1,
    S_LEAD_H = 3'd2,
    S_BIT_L  = 3'd3,
    S_BIT_H  = 3'd4,
    S_STOP_L = 3'd5,
    S_GAP    = 3'd6
  } state_t;

  typedef logic [20:0] cnt_t;

  if (LEAD_LOW < 1 || LEAD_HIGH < 1 || BIT_LOW < 1 || ZERO_HIGH < 1 ||
      ONE_HIGH < 1 || GAP < 1 || CARRIER_HALF < 1 || GAP > 2097152) begin : g_bad_param
    $error("nec_ir_tx: durations must be 1..2^21 cycles");
  end

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [4:0]  idx_q, idx_d;
  logic        ir_out_q, ir_out_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mark_d;
  logic        cnt_end;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      ir_out_q <= 1'b1;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      ir_out_q <= ir_out_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Each state loads N-1 on entry and leaves when the counter reaches 0: exactly N cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_end = (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_LEAD_L;
          cnt_d   = cnt_t'(LEAD_LOW - 1);
          shift_d = bus.DataIn;
          idx_d   = '0;
        end
      end
      S_LEAD_L: begin
        if (cnt_end) begin
          state_d = S_LEAD_H;
          cnt_d   = cnt_t'(LEAD_HIGH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LEAD_H: begin
        if (cnt_end) begin
          state_d = S_BIT_L;
          cnt_d   = cnt_t'(BIT_LOW - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BIT_L: begin
        if (cnt_end) begin
          state_d = S_BIT_H;
          cnt_d   = shift_q[0] ? cnt_t'(ONE_HIGH - 1) : cnt_t'(ZERO_HIGH - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_BIT_H: begin
        if (cnt_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_t'(BIT_LOW - 1);
          if (idx_q == 5'd31) begin
            state_d = S_STOP_L;
          end else begin
            state_d = S_BIT_L;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP_L: begin
        if (cnt_end) begin
          state_d = S_GAP;
          cnt_d   = cnt_t'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    mark_d   = (state_d == S_LEAD_L) || (state_d == S_BIT_L) || (state_d == S_STOP_L);
    ir_out_d = ~mark_d;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_GAP) && (state_d == S_IDLE);
  end

`ifdef NEC_TX_CARRIER_EN
  localparam int unsigned PW = $clog2(CARRIER_HALF + 1);
  typedef logic [PW-1:0] ph_t;

  ph_t  ph_q, ph_d;
  logic mark_entry;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) ph_q <= '0;
    else        ph_q <= ph_d;
  end

  // Marks are never adjacent, so any state change into a mark restarts the carrier phase.
  always_comb begin
    mark_entry = mark_d && (state_d != state_q);
    led_d      = 1'b0;
    ph_d       = '0;
    if (mark_entry) begin
      led_d = 1'b1;
      ph_d  = ph_t'(CARRIER_HALF - 1);
    end else if (mark_d) begin
      if (ph_q == '0) begin
        led_d = ~led_q;
        ph_d  = ph_t'(CARRIER_HALF - 1);
      end else begin
        led_d = led_q;
        ph_d  = ph_q - 1'b1;
      end
    end
  end
`else
  always_comb begin
    led_d = mark_d;
  end
`endif

  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.IrOut = ir_out_q;
  assign bus.IrLed = led_q;

endmodule
